alu_muldiv_unit: RTL
====================

Name: alu_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers.
- Successor to the single-cycle combinational ALU: adds WIDTH-generic MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Uses a start/busy/done handshake and a pipeline-flush abort.
- Sits beside the main ALU in EX; the hazard unit stalls MFHI/MFLO and new mul/div ops while busy=1.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and even.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- rs_data  input  WIDTH  operand A (multiplicand/dividend/MT source).
- rt_data  input  WIDTH  operand B (multiplier/divisor).
- abort  input  1  flush; cancels an in-flight op.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  iterative op in progress.
- done  output  1  one-cycle pulse: HI/LO just updated.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0; takes effect mid-operation with no partial HI/LO write.
- States: IDLE, CALC, FIX.

IDLE, on edge with start=1:
- MULT/MULTU/DIV/DIVU with nonzero divisor:
  - Latch operand magnitudes (signed ops: two's-complement absolute value) and result-sign flags.
  - busy←1, counter←0, →CALC.
- DIV/DIVU with rt_data=0:
  - busy←1, →FIX directly with a divide-by-zero flag.
- MTHI: hi←rs_data, done←1 next cycle, busy stays 0, stay IDLE.
- MTLO: same as MTHI, writing lo.
- Reserved op: ignored; no done, no state change.

CALC:
- One iteration per edge; counter increments; after WIDTH iterations →FIX.
- Multiply: radix-2 shift-add into a 2*WIDTH product register.
- Divide: restoring, one quotient bit per edge, MSB first.

FIX, one edge:
- Apply signs:
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- Write {hi,lo}: mult HI=upper, LO=lower; div LO=quotient, HI=remainder.
- Divide-by-zero: lo←all-ones, hi←rs_data (raw, no sign processing).
- busy←0, done←1, →IDLE.

Latency:
- start sampled at edge 0; done high in the cycle after edge WIDTH+1 (33 edges for WIDTH=32).
- Divide-by-zero: done after edge 1.

Other rules:
- done is high for exactly one cycle and deasserts automatically.
- busy and done are never high together.
- start while busy=1: ignored; operands not relatched; op completes unchanged.
- abort=1 in CALC or FIX: →IDLE next edge, busy←0, done stays 0, hi/lo keep prior values.
  - abort has priority over the FIX write on the same edge.
  - abort in IDLE with start=1: start is ignored.
- Overflow case DIV of -2^(WIDTH-1) by -1: lo=-2^(WIDTH-1) (0x80000000), hi=0; no trap.
- All arithmetic is modulo 2^WIDTH per half; MULTU/DIVU treat operands as unsigned.

Test Plan:
- Reset then MULT, rs=0xFFFFFFFD (-3), rt=5 → 33 edges later done=1 for one cycle; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy was high for edges 0..32.
- DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=0x1234, rt=0 → done after 2 edges; lo=0xFFFFFFFF, hi=0x1234.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, abort at iteration 10 → busy drops next edge, no done, hi/lo retain prior values. Then MTHI 0xA5A5A5A5 → hi updated with done one cycle later and busy never set.
- Second start with different operands during a busy MULT → ignored; first result correct. Separately, rst_n low mid-CALC → all outputs 0 immediately, asynchronously.
- WIDTH=8 build: MULT 0x80*0x80 → hi=0x40, lo=0x00, done after 9 edges; random signed/unsigned sweep vs. reference model.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers, start/busy/done
// handshake and flush abort. One shift-add or restoring-divide step per clock.
module alu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  // acc: product upper half / partial remainder; low: multiplier / dividend->quotient
  logic [WIDTH-1:0]   acc_q, acc_d, low_q, low_d, opnd_q, opnd_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & rs_data[WIDTH-1];
  assign b_neg     = signed_op & rt_data[WIDTH-1];
  assign a_mag     = a_neg ? -rs_data : rs_data;
  assign b_mag     = b_neg ? -rt_data : rt_data;

  assign mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, low_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  assign prod      = {acc_q, low_q};
  assign prod_fix  = neg_q ? -prod : prod;
  assign quo_fix   = neg_q ? -low_q : low_q;
  assign rem_fix   = neg_rem_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    low_d     = low_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (!op[2]) begin
            busy_d   = 1'b1;
            is_div_d = op[1];
            if (op[1] && (rt_data == '0)) begin
              // Divide-by-zero skips iteration; raw dividend parked for HI
              dz_d    = 1'b1;
              low_d   = rs_data;
              state_d = FIX;
            end else begin
              dz_d      = 1'b0;
              acc_d     = '0;
              cnt_d     = '0;
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              opnd_d    = op[1] ? b_mag : a_mag;
              low_d     = op[1] ? a_mag : b_mag;
              state_d   = CALC;
            end
          end else if (!op[1]) begin
            if (op[0]) lo_d = rs_data;
            else       hi_d = rs_data;
            done_d = 1'b1;
          end
        end
      end
      CALC: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            low_d = {mul_sum[0], low_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d = low_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      low_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
